// File: rtl/track_result_uart_tx.sv
// Serialises one tracking result (x, y, w, h) into an 11-byte 8N1 UART packet:
// AA 55 xH xL yH yL wH wL hH hL CS, where CS is the 8-bit wrapping sum of the payload bytes.
module track_result_uart_tx #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          BAUD     = 115_200,
  parameter logic [7:0]  HDR0     = 8'hAA,
  parameter logic [7:0]  HDR1     = 8'h55
) (
  input  logic        iclk,
  input  logic        s_rst_n,
  input  logic        tx_start,
  input  logic [15:0] result_x,
  input  logic [15:0] result_y,
  input  logic [15:0] result_w,
  input  logic [15:0] result_h,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_overrun
);

  localparam int              CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int              CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_BYTE    = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [3:0]         r_byte_idx;
  logic [7:0]         r_shift;
  logic [7:0]         r_cs;
  logic [63:0]        r_shadow;
  logic               r_txd;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;

  logic               w_bit_end;
  logic               w_accept;
  logic               w_start_end;
  logic               w_data_end;
  logic               w_byte_end;
  logic               w_pkt_end;
  logic [3:0]         w_next_idx;
  logic [7:0]         w_next_byte;
  logic               w_next_is_payload;

  assign w_bit_end         = (r_clk_cnt == BIT_LAST);
  assign w_next_idx        = r_byte_idx + 4'd1;
  assign w_next_is_payload = (w_next_idx >= 4'd2) && (w_next_idx <= 4'd9);

  // Byte for the slot after the current one; slot 10 is the running checksum.
  always_comb begin
    w_next_byte = r_cs;
    case (w_next_idx)
      4'd0:    w_next_byte = HDR0;
      4'd1:    w_next_byte = HDR1;
      4'd2:    w_next_byte = r_shadow[63:56];
      4'd3:    w_next_byte = r_shadow[55:48];
      4'd4:    w_next_byte = r_shadow[47:40];
      4'd5:    w_next_byte = r_shadow[39:32];
      4'd6:    w_next_byte = r_shadow[31:24];
      4'd7:    w_next_byte = r_shadow[23:16];
      4'd8:    w_next_byte = r_shadow[15:8];
      4'd9:    w_next_byte = r_shadow[7:0];
      default: w_next_byte = r_cs;
    endcase
  end

  always_ff @(posedge iclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start_end = 1'b0;
    w_data_end  = 1'b0;
    w_byte_end  = 1'b0;
    w_pkt_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_start_end = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) begin
          w_data_end  = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_pkt_end   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_byte_end  = 1'b1;
            w_state_nxt = ST_START;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_cs       <= '0;
      r_shadow   <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= tx_start && r_busy;
      r_done    <= w_pkt_end;
      r_clk_cnt <= ((r_state == ST_IDLE) || w_bit_end) ? '0 : r_clk_cnt + 1'b1;

      // Start bit is driven on the acceptance edge itself; header byte 0 needs no shadow data.
      if (w_accept) begin
        r_shadow   <= {result_x, result_y, result_w, result_h};
        r_shift    <= HDR0;
        r_byte_idx <= '0;
        r_bit_idx  <= '0;
        r_cs       <= '0;
        r_txd      <= 1'b0;
        r_busy     <= 1'b1;
      end

      if (w_start_end) begin
        r_txd     <= r_shift[0];
        r_shift   <= {1'b0, r_shift[7:1]};
        r_bit_idx <= '0;
      end

      if ((r_state == ST_DATA) && w_bit_end) begin
        if (w_data_end) begin
          r_txd <= 1'b1;
        end else begin
          r_txd     <= r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end

      if (w_byte_end) begin
        r_byte_idx <= w_next_idx;
        r_shift    <= w_next_byte;
        r_txd      <= 1'b0;
        if (w_next_is_payload) begin
          r_cs <= r_cs + w_next_byte;
        end
      end

      if (w_pkt_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign uart_txd   = r_txd;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;
  assign tx_overrun = r_overrun;

endmodule

// File: tb/tb_track_result_uart_tx.sv
// Scoreboarded bench: stimulus pushes expected packet bytes, done/overrun events;
// independent line decoder and event monitors pop and compare.
module tb_track_result_uart_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int C        = CLK_FREQ / BAUD;
  localparam int PKT      = 110 * C;

  logic        iclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [15:0] result_x = '0, result_y = '0, result_w = '0, result_h = '0;
  logic        uart_txd, tx_busy, tx_done, tx_overrun;

  track_result_uart_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .HDR0(8'hAA), .HDR1(8'h55)
  ) dut (
    .iclk(iclk), .s_rst_n(s_rst_n), .tx_start(tx_start),
    .result_x(result_x), .result_y(result_y), .result_w(result_w), .result_h(result_h),
    .uart_txd(uart_txd), .tx_busy(tx_busy), .tx_done(tx_done), .tx_overrun(tx_overrun)
  );

  always #5 iclk = ~iclk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          dones = 0;
  int          mon_bidx = 0;
  logic [7:0]  exp_q[$];
  int unsigned pstart_q[$];
  int unsigned ovr_q[$];

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push_pkt(input logic [15:0] x, y, w, h);
    logic [7:0] pl[8];
    int sum;
    sum = 0;
    pl = '{x[15:8], x[7:0], y[15:8], y[7:0], w[15:8], w[7:0], h[15:8], h[7:0]};
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      sum += int'(pl[i]);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  // Returns early when reset is seen so the decoder can resync on the next packet.
  task automatic wait_neg(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      if (!s_rst_n) begin
        ab = 1'b1;
        return;
      end
    end
  endtask

  initial begin : line_monitor
    bit         ab;
    bit         stop_ok;
    logic [7:0] d;
    forever begin
      ab = 1'b0;
      stop_ok = 1'b1;
      d = '0;
      do @(negedge iclk); while (!(s_rst_n && uart_txd === 1'b0));
      if (mon_bidx == 0) pstart_q.push_back(cyc);
      wait_neg(C / 2, ab);
      if (!ab) chk("start_bit", uart_txd, 0);
      for (int b = 0; b < 8 && !ab; b++) begin
        wait_neg(C, ab);
        d[b] = uart_txd;
      end
      if (!ab) wait_neg(C - C / 2, ab);
      for (int s = 0; s < C && !ab; s++) begin
        if (s > 0) wait_neg(1, ab);
        if (!ab && uart_txd !== 1'b1) stop_ok = 1'b0;
      end
      if (ab) begin
        mon_bidx = 0;
        continue;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %02h expected none", d);
      end else begin
        chk("byte", d, exp_q.pop_front());
      end
      chk("stop_bit_high", stop_ok, 1);
      mon_bidx = (mon_bidx == 10) ? 0 : mon_bidx + 1;
    end
  end

  always @(negedge iclk) begin
    if (s_rst_n && tx_done === 1'b1) begin
      dones++;
      chk("busy_low_at_done", tx_busy, 0);
      if (pstart_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got tx_done expected none (cycle %0d)", cyc);
      end else begin
        chk("pkt_cycles", cyc - pstart_q.pop_front(), PKT);
      end
    end
  end

  always @(negedge iclk) begin
    if (s_rst_n && tx_overrun === 1'b1) begin
      if (ovr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL overrun_unexpected: got pulse expected none (cycle %0d)", cyc);
      end else begin
        chk("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] x, y, w, h);
    @(negedge iclk);
    result_x = x; result_y = y; result_w = w; result_h = h;
    tx_start = 1'b1;
    push_pkt(x, y, w, h);
    @(negedge iclk);
    tx_start = 1'b0;
    chk("busy_after_accept", tx_busy, 1);
    chk("start_edge", uart_txd, 0);
  endtask

  task automatic overrun_pulse();
    @(negedge iclk);
    result_x = 16'($urandom); result_y = 16'($urandom);
    result_w = 16'($urandom); result_h = 16'($urandom);
    tx_start = 1'b1;
    ovr_q.push_back(cyc + 1);
    @(negedge iclk);
    tx_start = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pstart_q.size() != 0 || tx_busy !== 1'b0) && n < 3000) begin
      @(negedge iclk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL quiet_timeout: got busy/pending after %0d cycles expected idle", n);
    end
    @(negedge iclk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0;
    int n;
    int k;
    repeat (3) @(negedge iclk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_overrun", tx_overrun, 0);
    s_rst_n = 1'b1;
    repeat (2) @(negedge iclk);
    chk("idle_txd", uart_txd, 1);

    // Basic packet, then checksum wrap
    send(16'h0123, 16'h0456, 16'h0040, 16'h0030);
    wait_quiet();
    send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_quiet();

    // Inputs change one cycle after the latch edge
    send(16'h0123, 16'h0456, 16'h0040, 16'h0030);
    result_x = '0; result_y = '0; result_w = '0; result_h = '0;
    wait_quiet();

    // Overrun at cycle ~500 of the packet
    d0 = dones;
    send(16'h0123, 16'h0456, 16'h0040, 16'h0030);
    repeat (498) @(negedge iclk);
    overrun_pulse();
    wait_quiet();
    chk("single_done_on_overrun", dones - d0, 1);

    // Back-to-back: request presented in the tx_done cycle
    send(16'h0123, 16'h0456, 16'h0040, 16'h0030);
    n = 0;
    do begin
      @(negedge iclk);
      n++;
    end while (tx_done !== 1'b1 && n < 2000);
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL b2b_done_timeout: got no tx_done expected one");
    end
    result_x = 16'hBEEF; result_y = 16'h1234; result_w = 16'h00FE; result_h = 16'h8001;
    tx_start = 1'b1;
    push_pkt(16'hBEEF, 16'h1234, 16'h00FE, 16'h8001);
    @(negedge iclk);
    tx_start = 1'b0;
    chk("b2b_start_bit", uart_txd, 0);
    chk("b2b_busy", tx_busy, 1);
    wait_quiet();

    // Reset during byte 4
    send(16'h0123, 16'h0456, 16'h0040, 16'h0030);
    repeat (40 * C + 1) @(negedge iclk);
    chk("txd_before_reset", uart_txd, 0);
    #2;
    s_rst_n = 1'b0;
    exp_q.delete();
    pstart_q.delete();
    #1;
    chk("async_rst_txd", uart_txd, 1);
    chk("async_rst_busy", tx_busy, 0);
    repeat (3) @(negedge iclk);
    s_rst_n = 1'b1;
    @(negedge iclk);
    send(16'h0123, 16'h0456, 16'h0040, 16'h0030);
    wait_quiet();

    // Randomised packets with occasional overruns
    for (int it = 0; it < 8; it++) begin
      d0 = dones;
      send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(2, 1000);
        repeat (k) @(negedge iclk);
        overrun_pulse();
      end
      wait_quiet();
      chk("rand_one_done", dones - d0, 1);
      repeat ($urandom_range(0, 5)) @(negedge iclk);
    end

    chk("exp_bytes_drained", exp_q.size(), 0);
    chk("overruns_seen", ovr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
